// File: rtl/apb_timer_multi_pkg.sv
// Shared definitions for the multi-channel APB timer: register map, CTRL/STAT
// bit positions and prescaler select encodings.
package apb_timer_multi_pkg;

   localparam int CH_STRIDE = 32;
   localparam int CH_LSB    = $clog2(CH_STRIDE);

   localparam logic [4:0] OFF_CTRL = 5'h00;
   localparam logic [4:0] OFF_TDR  = 5'h04;
   localparam logic [4:0] OFF_CMP  = 5'h08;
   localparam logic [4:0] OFF_CNT  = 5'h0C;
   localparam logic [4:0] OFF_STAT = 5'h10;

   localparam int CTRL_W      = 9;
   localparam int CTRL_EN     = 0;
   localparam int CTRL_LOAD   = 1;
   localparam int CTRL_UD     = 2;
   localparam int CTRL_CKS_LO = 3;
   localparam int CTRL_CKS_HI = 4;
   localparam int CTRL_ARL    = 5;
   localparam int CTRL_OVFIE  = 6;
   localparam int CTRL_UDFIE  = 7;
   localparam int CTRL_CMPIE  = 8;

   localparam int STAT_W    = 3;
   localparam int STAT_OVF  = 0;
   localparam int STAT_UDF  = 1;
   localparam int STAT_CMPF = 2;

   typedef enum logic [1:0] {
      CKS_DIV2  = 2'd0,
      CKS_DIV4  = 2'd1,
      CKS_DIV8  = 2'd2,
      CKS_DIV16 = 2'd3
   } cks_e;

   // Low prescaler bits that must reach terminal count for a tick.
   function automatic logic [3:0] cks_mask(input cks_e cks);
      case (cks)
         CKS_DIV2:  return 4'b0001;
         CKS_DIV4:  return 4'b0011;
         CKS_DIV8:  return 4'b0111;
         CKS_DIV16: return 4'b1111;
         default:   return 4'b0001;
      endcase
   endfunction

endpackage

// File: rtl/apb_timer_multi_channel.sv
// One timer channel: prescaler, up/down counter with optional auto-reload,
// compare match, sticky W1C flags and the channel's interrupt term.
module timer_channel
   import apb_timer_multi_pkg::*;
#(
   parameter int WIDTH = 16
) (
   input  logic              pclk,
   input  logic              preset,
   input  logic              wr_ctrl,
   input  logic              wr_tdr,
   input  logic              wr_cmp,
   input  logic              wr_stat,
   input  logic [31:0]       wdata,
   output logic [CTRL_W-1:0] ctrl,
   output logic [WIDTH-1:0]  tdr,
   output logic [WIDTH-1:0]  cmp,
   output logic [WIDTH-1:0]  cnt,
   output logic [STAT_W-1:0] stat,
   output logic              irq_term
);

   localparam logic [WIDTH-1:0] MAX = '1;

   logic [CTRL_W-1:0] ctrl_q, ctrl_d;
   logic [WIDTH-1:0]  tdr_q, tdr_d;
   logic [WIDTH-1:0]  cmp_q, cmp_d;
   logic [WIDTH-1:0]  cnt_q, cnt_d;
   logic [STAT_W-1:0] stat_q, stat_d;
   logic [3:0]        psc_q, psc_d;

   logic              load;
   logic              tick;
   logic              wrap;
   logic [WIDTH-1:0]  cnt_nxt;
   logic              unused_wdata;

   assign unused_wdata = ^wdata;

   always_comb begin
      load = wr_ctrl & wdata[CTRL_LOAD];
      // Prescaler counts down; a tick fires when its selected low bits hit 1.
      tick = ctrl_q[CTRL_EN] & ~load &
             ((psc_q & cks_mask(cks_e'(ctrl_q[CTRL_CKS_HI:CTRL_CKS_LO]))) == 4'd1);

      if (ctrl_q[CTRL_UD]) begin
         wrap    = (cnt_q == '0);
         cnt_nxt = wrap ? (ctrl_q[CTRL_ARL] ? tdr_q : MAX) : cnt_q - WIDTH'(1);
      end else begin
         wrap    = (cnt_q == MAX);
         cnt_nxt = wrap ? (ctrl_q[CTRL_ARL] ? tdr_q : '0) : cnt_q + WIDTH'(1);
      end

      ctrl_d = ctrl_q;
      tdr_d  = tdr_q;
      cmp_d  = cmp_q;
      cnt_d  = cnt_q;
      psc_d  = psc_q;
      stat_d = stat_q;

      if (wr_ctrl) begin
         ctrl_d            = wdata[CTRL_W-1:0];
         ctrl_d[CTRL_LOAD] = 1'b0;
      end
      if (wr_tdr) tdr_d = wdata[WIDTH-1:0];
      if (wr_cmp) cmp_d = wdata[WIDTH-1:0];
      if (wr_stat) stat_d = stat_q & ~wdata[STAT_W-1:0];

      if (load) begin
         cnt_d = tdr_q;
         psc_d = 4'd0;
      end else if (!ctrl_q[CTRL_EN]) begin
         psc_d = 4'd0;
      end else begin
         psc_d = psc_q - 4'd1;
         if (tick) begin
            cnt_d = cnt_nxt;
            // Flag sets are applied after the W1C clear so a same-cycle set wins.
            if (wrap) begin
               if (ctrl_q[CTRL_UD]) stat_d[STAT_UDF] = 1'b1;
               else                 stat_d[STAT_OVF] = 1'b1;
            end
            if (cnt_nxt == cmp_q) stat_d[STAT_CMPF] = 1'b1;
         end
      end
   end

   always_ff @(posedge pclk) begin
      if (preset) begin
         ctrl_q <= '0;
         tdr_q  <= '0;
         cmp_q  <= '0;
         cnt_q  <= '0;
         stat_q <= '0;
         psc_q  <= '0;
      end else begin
         ctrl_q <= ctrl_d;
         tdr_q  <= tdr_d;
         cmp_q  <= cmp_d;
         cnt_q  <= cnt_d;
         stat_q <= stat_d;
         psc_q  <= psc_d;
      end
   end

   assign ctrl     = ctrl_q;
   assign tdr      = tdr_q;
   assign cmp      = cmp_q;
   assign cnt      = cnt_q;
   assign stat     = stat_q;
   assign irq_term = |(stat_q & {ctrl_q[CTRL_CMPIE], ctrl_q[CTRL_UDFIE], ctrl_q[CTRL_OVFIE]});

endmodule

// File: rtl/apb_timer_multi.sv
// APB slave wrapping NUM_CH independent timer channels; decodes channel and
// register offset, muxes read data, flags bad accesses and combines interrupts.
module apb_timer_multi
   import apb_timer_multi_pkg::*;
#(
   parameter int NUM_CH = 4,
   parameter int WIDTH  = 16,
   parameter int ADDR_W = 8
) (
   input  logic              pclk,
   input  logic              preset,
   input  logic              psel,
   input  logic              penable,
   input  logic              pwrite,
   input  logic [ADDR_W-1:0] paddr,
   input  logic [31:0]       pwdata,
   output logic [31:0]       prdata,
   output logic              pready,
   output logic              pslverr,
   output logic              irq
);

   logic              access;
   logic [2:0]        ch;
   logic [4:0]        off;
   logic              off_ok;
   logic              err;
   logic              wr_en;
   logic [31:0]       rd_mux;
   logic              irq_q, irq_d;
   logic              unused_paddr;

   logic [CTRL_W-1:0] ch_ctrl [NUM_CH];
   logic [WIDTH-1:0]  ch_tdr  [NUM_CH];
   logic [WIDTH-1:0]  ch_cmp  [NUM_CH];
   logic [WIDTH-1:0]  ch_cnt  [NUM_CH];
   logic [STAT_W-1:0] ch_stat [NUM_CH];
   logic [NUM_CH-1:0] ch_irq;

   assign unused_paddr = ^paddr;
   assign access       = psel & penable;
   assign ch           = paddr[CH_LSB +: 3];
   assign off          = paddr[4:0];

   always_comb begin
      off_ok = (off == OFF_CTRL) || (off == OFF_TDR) || (off == OFF_CMP) ||
               (off == OFF_CNT)  || (off == OFF_STAT);
      err    = access & (({1'b0, ch} >= 4'(NUM_CH)) || !off_ok ||
                         (pwrite && (off == OFF_CNT)));
      wr_en  = access & pwrite & ~err;
   end

   for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
      logic sel;
      assign sel = wr_en && (ch == 3'(g));

      timer_channel #(.WIDTH(WIDTH)) u_ch (
         .pclk     (pclk),
         .preset   (preset),
         .wr_ctrl  (sel && (off == OFF_CTRL)),
         .wr_tdr   (sel && (off == OFF_TDR)),
         .wr_cmp   (sel && (off == OFF_CMP)),
         .wr_stat  (sel && (off == OFF_STAT)),
         .wdata    (pwdata),
         .ctrl     (ch_ctrl[g]),
         .tdr      (ch_tdr[g]),
         .cmp      (ch_cmp[g]),
         .cnt      (ch_cnt[g]),
         .stat     (ch_stat[g]),
         .irq_term (ch_irq[g])
      );
   end

   always_comb begin
      rd_mux = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         if (ch == 3'(i)) begin
            case (off)
               OFF_CTRL: rd_mux = 32'(ch_ctrl[i]);
               OFF_TDR:  rd_mux = 32'(ch_tdr[i]);
               OFF_CMP:  rd_mux = 32'(ch_cmp[i]);
               OFF_CNT:  rd_mux = 32'(ch_cnt[i]);
               OFF_STAT: rd_mux = 32'(ch_stat[i]);
               default:  rd_mux = '0;
            endcase
         end
      end
      irq_d = |ch_irq;
   end

   always_ff @(posedge pclk) begin
      if (preset) irq_q <= 1'b0;
      else        irq_q <= irq_d;
   end

   assign prdata  = (access && !pwrite && !err) ? rd_mux : '0;
   assign pready  = 1'b1;
   assign pslverr = err;
   assign irq     = irq_q;

endmodule

// File: tb/tb_apb_timer_multi.sv
// Bench for apb_timer_multi: directed scenarios plus random APB traffic, all
// checked against a cycle-level behavioural model of the register rules.
module tb_apb_timer_multi;

   localparam int NUM_CH = 4;
   localparam int WIDTH  = 16;
   localparam int ADDR_W = 8;
   localparam logic [31:0] MAXV = 32'h0000_FFFF;

   logic        pclk = 1'b0;
   logic        preset, psel, penable, pwrite;
   logic [7:0]  paddr;
   logic [31:0] pwdata, prdata;
   logic        pready, pslverr, irq;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;

   logic [31:0] m_ctrl [NUM_CH];
   logic [31:0] m_tdr  [NUM_CH];
   logic [31:0] m_cmp  [NUM_CH];
   logic [31:0] m_cnt  [NUM_CH];
   logic [31:0] m_stat [NUM_CH];
   int          m_ph   [NUM_CH];
   logic        m_irq;

   logic [4:0] offs [5] = '{5'h00, 5'h04, 5'h08, 5'h0C, 5'h10};

   apb_timer_multi #(.NUM_CH(NUM_CH), .WIDTH(WIDTH), .ADDR_W(ADDR_W)) dut (
      .pclk(pclk), .preset(preset), .psel(psel), .penable(penable), .pwrite(pwrite),
      .paddr(paddr), .pwdata(pwdata), .prdata(prdata), .pready(pready),
      .pslverr(pslverr), .irq(irq)
   );

   always #5 pclk = ~pclk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   function automatic logic [7:0] ra(input int c, input logic [4:0] o);
      logic [2:0] c3;
      c3 = 3'(c);
      return {c3, o};
   endfunction

   function automatic logic m_err(input logic [7:0] a, input logic w);
      logic [4:0] o;
      int c;
      o = a[4:0];
      c = int'(a[7:5]);
      return (c >= NUM_CH) || !(o == 5'h00 || o == 5'h04 || o == 5'h08 || o == 5'h0C || o == 5'h10)
             || (w && o == 5'h0C);
   endfunction

   function automatic logic [31:0] m_read(input logic [7:0] a);
      int c;
      if (m_err(a, 1'b0)) return 32'd0;
      c = int'(a[7:5]);
      case (a[4:0])
         5'h00:   return m_ctrl[c];
         5'h04:   return m_tdr[c];
         5'h08:   return m_cmp[c];
         5'h0C:   return m_cnt[c];
         default: return m_stat[c];
      endcase
   endfunction

   // Advance the model by one pclk edge using the pre-edge state and the driven inputs.
   function automatic void model_step();
      logic acc, err, wr, load;
      logic [4:0] o;
      int chn, cks, dv;
      logic [31:0] ct, st, cn;
      acc = psel && penable;
      o   = paddr[4:0];
      chn = int'(paddr[7:5]);
      err = acc && m_err(paddr, pwrite);
      if (preset) begin
         for (int c = 0; c < NUM_CH; c++) begin
            m_ctrl[c] = 0; m_tdr[c] = 0; m_cmp[c] = 0; m_cnt[c] = 0; m_stat[c] = 0; m_ph[c] = 0;
         end
         m_irq = 1'b0;
         return;
      end
      m_irq = 1'b0;
      for (int c = 0; c < NUM_CH; c++)
         if ((m_stat[c] & ((m_ctrl[c] >> 6) & 32'd7)) != 0) m_irq = 1'b1;
      for (int c = 0; c < NUM_CH; c++) begin
         wr   = acc && pwrite && !err && (chn == c);
         ct   = m_ctrl[c];
         cks  = int'((ct >> 3) & 32'd3);
         dv   = 2 << cks;
         load = wr && (o == 5'h00) && pwdata[1];
         st   = m_stat[c];
         cn   = m_cnt[c];
         if (wr && o == 5'h10) st = st & ~(pwdata & 32'd7);
         if (load) begin
            cn = m_tdr[c];
            m_ph[c] = 0;
         end else if (ct[0] == 1'b0) begin
            m_ph[c] = 0;
         end else begin
            if ((m_ph[c] + 1) % dv == 0) begin
               if (ct[2] == 1'b0) begin
                  if (cn == MAXV) begin cn = ct[5] ? m_tdr[c] : 32'd0; st = st | 32'd1; end
                  else cn = cn + 1;
               end else begin
                  if (cn == 0) begin cn = ct[5] ? m_tdr[c] : MAXV; st = st | 32'd2; end
                  else cn = cn - 1;
               end
               if (cn == m_cmp[c]) st = st | 32'd4;
            end
            m_ph[c] = m_ph[c] + 1;
         end
         m_cnt[c]  = cn;
         m_stat[c] = st;
         if (wr) begin
            case (o)
               5'h00:   m_ctrl[c] = pwdata & 32'h1FD;
               5'h04:   m_tdr[c]  = pwdata & MAXV;
               5'h08:   m_cmp[c]  = pwdata & MAXV;
               default: ;
            endcase
         end
      end
   endfunction

   task automatic tick_cycle();
      @(posedge pclk);
      model_step();
      cyc++;
      #1;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) tick_cycle();
   endtask

   task automatic idle_until(input int target);
      for (int i = 0; i < 1000 && cyc < target; i++) tick_cycle();
   endtask

   task automatic apb_write(input logic [7:0] a, input logic [31:0] d, output logic e, output logic xe);
      psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = a; pwdata = d;
      tick_cycle();
      penable = 1'b1;
      #1;
      e  = pslverr;
      xe = m_err(a, 1'b1);
      tick_cycle();
      psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
   endtask

   task automatic apb_read(input logic [7:0] a, output logic [31:0] d, output logic e,
                           output logic [31:0] xd, output logic xe);
      psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = a;
      tick_cycle();
      penable = 1'b1;
      #1;
      d  = prdata;
      e  = pslverr;
      xd = m_read(a);
      xe = m_err(a, 1'b0);
      tick_cycle();
      psel = 1'b0; penable = 1'b0;
   endtask

   task automatic test_reset();
      logic [31:0] d, xd;
      logic e, xe;
      preset = 1'b1; psel = 1'b0; penable = 1'b0; pwrite = 1'b0; paddr = '0; pwdata = '0;
      idle(2);
      preset = 1'b0;
      total++; if (irq !== 1'b0) begin bad++; $display("FAIL reset_irq got=%b exp=0", irq); end
      total++; if (pready !== 1'b1) begin bad++; $display("FAIL reset_pready got=%b exp=1", pready); end
      total++; if (prdata !== 32'd0 || pslverr !== 1'b0)
         begin bad++; $display("FAIL reset_idle_bus prdata=%h pslverr=%b exp=0/0", prdata, pslverr); end
      for (int c = 0; c < NUM_CH; c++)
         for (int k = 0; k < 5; k++) begin
            apb_read(ra(c, offs[k]), d, e, xd, xe);
            total++; if (d !== 32'd0 || e !== 1'b0)
               begin bad++; $display("FAIL reset_reg ch%0d off%h got=%h err=%b exp=0", c, offs[k], d, e); end
         end
      apb_read(ra(0, 5'h14), d, e, xd, xe);
      total++; if (e !== 1'b1) begin bad++; $display("FAIL bad_offset_err got=%b exp=1", e); end
      apb_read(ra(NUM_CH, 5'h00), d, e, xd, xe);
      total++; if (e !== 1'b1 || d !== 32'd0)
         begin bad++; $display("FAIL bad_channel_err got err=%b d=%h exp=1/0", e, d); end
   endtask

   task automatic test_up_overflow();
      logic [31:0] d, xd;
      logic e, xe;
      logic [31:0] seq [4] = '{32'hFFFD, 32'hFFFE, 32'hFFFF, 32'h0000};
      apb_write(ra(0, 5'h04), 32'hFFFD, e, xe);
      apb_write(ra(0, 5'h00), 32'h043, e, xe);
      for (int k = 0; k < 4; k++) begin
         apb_read(ra(0, 5'h0C), d, e, xd, xe);
         total++; if (d !== seq[k] || d !== xd)
            begin bad++; $display("FAIL up_seq[%0d] got=%h exp=%h model=%h", k, d, seq[k], xd); end
      end
      apb_read(ra(0, 5'h10), d, e, xd, xe);
      total++; if (d[0] !== 1'b1 || d !== xd)
         begin bad++; $display("FAIL up_ovf_flag got=%h exp_bit0=1 model=%h", d, xd); end
      total++; if (irq !== 1'b1 || irq !== m_irq)
         begin bad++; $display("FAIL up_ovf_irq got=%b exp=1", irq); end
      apb_write(ra(0, 5'h10), 32'h1, e, xe);
      tick_cycle();
      total++; if (irq !== 1'b0) begin bad++; $display("FAIL up_w1c_irq got=%b exp=0", irq); end
      apb_read(ra(0, 5'h10), d, e, xd, xe);
      total++; if (d[0] !== 1'b0 || d !== xd)
         begin bad++; $display("FAIL up_w1c_flag got=%h exp_bit0=0 model=%h", d, xd); end
      apb_write(ra(0, 5'h00), 32'h0, e, xe);
      apb_write(ra(0, 5'h10), 32'h7, e, xe);
   endtask

   task automatic test_down_arl();
      logic [31:0] d, xd;
      logic e, xe;
      logic [31:0] seq [9] = '{3, 3, 2, 2, 1, 1, 0, 0, 3};
      apb_write(ra(1, 5'h04), 32'h3, e, xe);
      apb_write(ra(1, 5'h00), 32'h02F, e, xe);
      for (int k = 0; k < 9; k++) begin
         apb_read(ra(1, 5'h0C), d, e, xd, xe);
         total++; if (d !== seq[k] || d !== xd)
            begin bad++; $display("FAIL down_seq[%0d] got=%h exp=%h model=%h", k, d, seq[k], xd); end
      end
      apb_read(ra(1, 5'h10), d, e, xd, xe);
      total++; if (d[1] !== 1'b1 || d !== xd)
         begin bad++; $display("FAIL down_udf_flag got=%h exp_bit1=1 model=%h", d, xd); end
      apb_write(ra(1, 5'h00), 32'h0, e, xe);
      apb_write(ra(1, 5'h10), 32'h7, e, xe);
   endtask

   task automatic test_compare();
      logic [31:0] d, xd;
      logic e, xe;
      apb_write(ra(2, 5'h08), 32'h5, e, xe);
      apb_write(ra(2, 5'h00), 32'h101, e, xe);
      idle(14);
      total++; if (irq !== 1'b1 || irq !== m_irq)
         begin bad++; $display("FAIL cmp_irq got=%b exp=1", irq); end
      apb_read(ra(2, 5'h10), d, e, xd, xe);
      total++; if (d[2] !== 1'b1 || d !== xd)
         begin bad++; $display("FAIL cmp_flag got=%h exp_bit2=1 model=%h", d, xd); end
      apb_write(ra(2, 5'h00), 32'h0, e, xe);
      apb_write(ra(2, 5'h10), 32'h7, e, xe);
      apb_write(ra(2, 5'h04), 32'h0, e, xe);
      apb_write(ra(2, 5'h00), 32'h003, e, xe);
      idle(14);
      total++; if (irq !== 1'b0) begin bad++; $display("FAIL cmp_noie_irq got=%b exp=0", irq); end
      apb_read(ra(2, 5'h10), d, e, xd, xe);
      total++; if (d[2] !== 1'b1 || d !== xd)
         begin bad++; $display("FAIL cmp_noie_flag got=%h exp_bit2=1 model=%h", d, xd); end
      apb_read(ra(2, 5'h0C), d, e, xd, xe);
      total++; if (d !== xd) begin bad++; $display("FAIL cmp_cnt got=%h exp=%h", d, xd); end
      apb_write(ra(2, 5'h00), 32'h0, e, xe);
      apb_write(ra(2, 5'h10), 32'h7, e, xe);
   endtask

   task automatic test_collisions();
      logic [31:0] d, xd, c0;
      logic e, xe;
      int l, a;
      apb_write(ra(3, 5'h04), 32'hFFFF, e, xe);
      apb_write(ra(3, 5'h00), 32'h03B, e, xe);
      l = cyc;
      idle_until(l + 30);
      apb_write(ra(3, 5'h10), 32'h1, e, xe);
      apb_read(ra(3, 5'h10), d, e, xd, xe);
      total++; if (d[0] !== 1'b1 || d !== xd)
         begin bad++; $display("FAIL w1c_vs_set got=%h exp_bit0=1 model=%h", d, xd); end
      idle_until(l + 38);
      apb_write(ra(3, 5'h10), 32'h1, e, xe);
      apb_read(ra(3, 5'h10), d, e, xd, xe);
      total++; if (d[0] !== 1'b0 || d !== xd)
         begin bad++; $display("FAIL w1c_plain got=%h exp_bit0=0 model=%h", d, xd); end
      apb_write(ra(3, 5'h04), 32'h1234, e, xe);
      idle_until(l + 78);
      apb_write(ra(3, 5'h00), 32'h01B, e, xe);
      a = cyc;
      apb_read(ra(3, 5'h0C), d, e, xd, xe);
      total++; if (d !== 32'h1234 || d !== xd)
         begin bad++; $display("FAIL load_on_tick got=%h exp=1234 model=%h", d, xd); end
      idle_until(a + 14);
      apb_read(ra(3, 5'h0C), d, e, xd, xe);
      total++; if (d !== 32'h1234 || d !== xd)
         begin bad++; $display("FAIL load_full_period got=%h exp=1234 model=%h", d, xd); end
      apb_read(ra(3, 5'h0C), d, e, xd, xe);
      total++; if (d !== 32'h1235 || d !== xd)
         begin bad++; $display("FAIL load_first_tick got=%h exp=1235 model=%h", d, xd); end
      apb_write(ra(3, 5'h00), 32'h0, e, xe);
      apb_read(ra(3, 5'h0C), c0, e, xd, xe);
      apb_write(ra(3, 5'h0C), 32'hAAAA, e, xe);
      total++; if (e !== 1'b1 || e !== xe)
         begin bad++; $display("FAIL cnt_write_err got=%b exp=1", e); end
      apb_read(ra(3, 5'h0C), d, e, xd, xe);
      total++; if (d !== 32'h1235 || d !== xd)
         begin bad++; $display("FAIL cnt_write_nochange got=%h exp=1235 model=%h", d, xd); end
      apb_write(ra(3, 5'h10), 32'h7, e, xe);
   endtask

   task automatic test_freeze_reset();
      logic [31:0] d, xd;
      logic e, xe;
      apb_write(ra(0, 5'h04), 32'h55, e, xe);
      apb_write(ra(0, 5'h00), 32'h005, e, xe);
      idle(20);
      apb_write(ra(0, 5'h00), 32'h004, e, xe);
      apb_read(ra(0, 5'h0C), d, e, xd, xe);
      total++; if (d !== xd) begin bad++; $display("FAIL freeze_before got=%h exp=%h", d, xd); end
      idle(50);
      apb_read(ra(0, 5'h0C), d, e, xd, xe);
      total++; if (d !== xd) begin bad++; $display("FAIL freeze_after got=%h exp=%h", d, xd); end
      apb_write(ra(0, 5'h00), 32'h001, e, xe);
      idle(7);
      preset = 1'b1;
      tick_cycle();
      preset = 1'b0;
      total++; if (irq !== 1'b0) begin bad++; $display("FAIL midreset_irq got=%b exp=0", irq); end
      for (int c = 0; c < NUM_CH; c++)
         for (int k = 0; k < 5; k++) begin
            apb_read(ra(c, offs[k]), d, e, xd, xe);
            if (k == 3) begin
               total++; if (d !== xd)
                  begin bad++; $display("FAIL midreset_cnt ch%0d got=%h exp=%h", c, d, xd); end
            end else begin
               total++; if (d !== 32'd0)
                  begin bad++; $display("FAIL midreset_reg ch%0d off%h got=%h exp=0", c, offs[k], d); end
            end
         end
   endtask

   task automatic test_random();
      logic [31:0] d, xd, wd;
      logic e, xe;
      logic [4:0] o;
      int chn, os;
      for (int n = 0; n < 400; n++) begin
         chn = ($urandom_range(0, 9) == 0) ? int'($urandom_range(NUM_CH, 7)) : int'($urandom_range(0, NUM_CH - 1));
         os  = int'($urandom_range(0, 5));
         o   = (os == 5) ? (($urandom_range(0, 1) == 1) ? 5'h14 : 5'h02) : offs[os];
         case (os)
            0: begin wd = $urandom; wd[0] = ($urandom_range(0, 3) != 0); end
            1: wd = ($urandom & 32'hFFFF_0000) |
                    (($urandom_range(0, 1) == 1) ? (32'hFFFF - $urandom_range(0, 8)) : $urandom_range(0, 8));
            2: wd = ($urandom_range(0, 1) == 1) ? (32'hFFFF - $urandom_range(0, 8)) : $urandom_range(0, 12);
            default: wd = $urandom;
         endcase
         if ($urandom_range(0, 1) == 1) begin
            apb_write(ra(chn, o), wd, e, xe);
            total++; if (e !== xe)
               begin bad++; $display("FAIL rnd_wr_err[%0d] a=%h got=%b exp=%b", n, ra(chn, o), e, xe); end
         end else begin
            apb_read(ra(chn, o), d, e, xd, xe);
            total++; if (d !== xd || e !== xe)
               begin bad++; $display("FAIL rnd_rd[%0d] a=%h got=%h/%b exp=%h/%b", n, ra(chn, o), d, e, xd, xe); end
         end
         idle(int'($urandom_range(0, 4)));
         total++; if (irq !== m_irq)
            begin bad++; $display("FAIL rnd_irq[%0d] got=%b exp=%b", n, irq, m_irq); end
      end
   endtask

   initial begin
      test_reset();
      test_up_overflow();
      test_down_arl();
      test_compare();
      test_collisions();
      test_freeze_reset();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
